// File: rtl/bram_pattern_engine.sv
// Bank-level traffic generator/checker: fills a single-port BRAM bank with a pattern,
// reads it back through the 1-cycle registered dout and counts mismatches.
module bram_pattern_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned ERR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [1:0]            pattern_sel_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ERR_WIDTH-1:0]  err_count_o,
  output logic                  first_err_valid_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic [DATA_WIDTH-1:0] first_err_data_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_din_o,
  input  logic [DATA_WIDTH-1:0] mem_dout_i
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] PatEven  = {(DATA_WIDTH / 2){2'b01}};
  localparam logic [DATA_WIDTH-1:0] PatOdd   = ~PatEven;
  localparam logic [ERR_WIDTH-1:0]  ErrMax   = '1;

  // An all-zero LFSR would lock up, so a zero seed starts from 1.
  function automatic logic [DATA_WIDTH-1:0] lfsr_init(input logic [DATA_WIDTH-1:0] s);
    return (s == '0) ? DATA_WIDTH'(1) : s;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lfsr_next(input logic [DATA_WIDTH-1:0] x);
    return {x[DATA_WIDTH-2:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  state_e                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [1:0]              pat_q, pat_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   lfsr_q, lfsr_d;
  logic                    cmp_vld_q, cmp_vld_d;
  logic [DATA_WIDTH-1:0]   exp_data_q, exp_data_d;
  logic [ADDR_WIDTH-1:0]   exp_addr_q, exp_addr_d;
  logic [ERR_WIDTH-1:0]    err_q, err_d;
  logic                    fev_q, fev_d;
  logic [ADDR_WIDTH-1:0]   fea_q, fea_d;
  logic [DATA_WIDTH-1:0]   fed_q, fed_d;
  logic [DATA_WIDTH-1:0]   pat_word;

  always_comb begin
    case (pat_q)
      2'd0:    pat_word = addr_q[DATA_WIDTH-1:0];
      2'd1:    pat_word = seed_q;
      2'd2:    pat_word = addr_q[0] ? PatOdd : PatEven;
      default: pat_word = lfsr_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pat_d      = pat_q;
    seed_d     = seed_q;
    addr_d     = addr_q;
    lfsr_d     = lfsr_q;
    cmp_vld_d  = 1'b0;
    exp_data_d = exp_data_q;
    exp_addr_d = exp_addr_q;
    err_d      = err_q;
    fev_d      = fev_q;
    fea_d      = fea_q;
    fed_d      = fed_q;
    mem_en_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_din_o  = '0;

    // Compare slot trails each read issue by one cycle, so it lands in READ or DRAIN.
    if (cmp_vld_q && (mem_dout_i != exp_data_q)) begin
      if (err_q != ErrMax) err_d = err_q + ERR_WIDTH'(1);
      if (!fev_q) begin
        fev_d = 1'b1;
        fea_d = exp_addr_q;
        fed_d = mem_dout_i;
      end
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d  = mode_i;
          pat_d   = pattern_sel_i;
          seed_d  = seed_i;
          err_d   = '0;
          fev_d   = 1'b0;
          fea_d   = '0;
          fed_d   = '0;
          addr_d  = '0;
          lfsr_d  = lfsr_init(seed_i);
          state_d = (mode_i == 2'd1) ? StRead : StWrite;
        end
      end
      StWrite: begin
        mem_en_o   = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = addr_q;
        mem_din_o  = pat_word;
        addr_d     = addr_q + ADDR_WIDTH'(1);
        lfsr_d     = lfsr_next(lfsr_q);
        if (addr_q == LastAddr) begin
          addr_d  = '0;
          lfsr_d  = lfsr_init(seed_q);
          state_d = (mode_q == 2'd0) ? StDone : StRead;
        end
      end
      StRead: begin
        mem_en_o   = 1'b1;
        mem_addr_o = addr_q;
        cmp_vld_d  = 1'b1;
        exp_data_d = pat_word;
        exp_addr_d = addr_q;
        addr_d     = addr_q + ADDR_WIDTH'(1);
        lfsr_d     = lfsr_next(lfsr_q);
        if (addr_q == LastAddr) begin
          addr_d  = '0;
          state_d = StDrain;
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= '0;
      pat_q      <= '0;
      seed_q     <= '0;
      addr_q     <= '0;
      lfsr_q     <= '0;
      cmp_vld_q  <= 1'b0;
      exp_data_q <= '0;
      exp_addr_q <= '0;
      err_q      <= '0;
      fev_q      <= 1'b0;
      fea_q      <= '0;
      fed_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pat_q      <= pat_d;
      seed_q     <= seed_d;
      addr_q     <= addr_d;
      lfsr_q     <= lfsr_d;
      cmp_vld_q  <= cmp_vld_d;
      exp_data_q <= exp_data_d;
      exp_addr_q <= exp_addr_d;
      err_q      <= err_d;
      fev_q      <= fev_d;
      fea_q      <= fea_d;
      fed_q      <= fed_d;
    end
  end

  assign busy_o            = (state_q == StWrite) || (state_q == StRead) || (state_q == StDrain);
  assign done_o            = (state_q == StDone);
  assign err_count_o       = err_q;
  assign first_err_valid_o = fev_q;
  assign first_err_addr_o  = fea_q;
  assign first_err_data_o  = fed_q;

endmodule
